data_bus_responder: RTL

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder_pkg.sv | 25 ++
 rtl/data_bus_responder_mmio_timer.sv | 57 +++++
 rtl/data_bus_responder.sv | 76 +++++++
 3 files changed

// File: rtl/data_bus_responder_pkg.sv
// Shared address-map constants, timer register selects and CTRL bit positions
// for the data bus responder and its timer.
package data_bus_responder_pkg;

  localparam logic [31:0] TMR_BASE = 32'h8000_0000;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_W      = 3;

  typedef enum logic [1:0] {
    TMR_LOAD   = 2'd0,
    TMR_COUNT  = 2'd1,
    TMR_CTRL   = 2'd2,
    TMR_STATUS = 2'd3
  } tmr_reg_e;

  typedef struct packed {
    logic        we;
    tmr_reg_e    sel;
    logic [31:0] wdata;
  } tmr_wr_t;

endpackage

// File: rtl/data_bus_responder_mmio_timer.sv
// Memory-mapped down-counter: LOAD/COUNT/CTRL/STATUS plus a level interrupt
// derived only from registered state.
module mmio_timer
  import data_bus_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  tmr_wr_t           i_wr,
  output logic [31:0]       o_load,
  output logic [31:0]       o_count,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_pending,
  output logic              o_irq
);

  logic [31:0]       r_load, r_count;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_pending;

  logic        w_expire, w_clr;
  logic [31:0] w_count_nxt;

  assign w_expire = r_ctrl[CTRL_EN] && (r_count == 32'd1);
  assign w_clr    = i_wr.we && (i_wr.sel == TMR_STATUS) && i_wr.wdata[0];

  // A LOAD write overrides both the decrement and the expiry reload.
  always_comb begin
    w_count_nxt = r_count;
    if (i_wr.we && i_wr.sel == TMR_LOAD)
      w_count_nxt = i_wr.wdata;
    else if (w_expire)
      w_count_nxt = r_ctrl[CTRL_RELOAD] ? r_load : 32'd0;
    else if (r_ctrl[CTRL_EN] && r_count > 32'd1)
      w_count_nxt = r_count - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load    <= '0;
      r_count   <= '0;
      r_ctrl    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_pending <= w_expire | (r_pending & ~w_clr);
      if (i_wr.we && i_wr.sel == TMR_LOAD) r_load <= i_wr.wdata;
      if (i_wr.we && i_wr.sel == TMR_CTRL) r_ctrl <= i_wr.wdata[CTRL_W-1:0];
    end
  end

  assign o_load    = r_load;
  assign o_count   = r_count;
  assign o_ctrl    = r_ctrl;
  assign o_pending = r_pending;
  assign o_irq     = r_pending & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/data_bus_responder.sv
// Core-side data bus: word RAM plus memory-mapped timer, zero-latency reads,
// writes on the clock edge.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        interrupter
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] r_mem [RAM_WORDS];

  logic              w_ram_hit, w_tmr_hit;
  logic [AW-1:0]     w_idx;
  tmr_reg_e          w_sel;
  tmr_wr_t           w_tmr_wr;
  logic [31:0]       w_load, w_count, w_rdata;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_pending;
  logic              w_unused_lsbs;

  assign w_ram_hit     = (mem_addr[31:AW+2] == '0);
  assign w_tmr_hit     = (mem_addr[31:4] == TMR_BASE[31:4]);
  assign w_idx         = mem_addr[AW+1:2];
  assign w_sel         = tmr_reg_e'(mem_addr[3:2]);
  assign w_unused_lsbs = ^mem_addr[1:0];

  assign w_tmr_wr.we    = mem_wen & w_tmr_hit;
  assign w_tmr_wr.sel   = w_sel;
  assign w_tmr_wr.wdata = mem_dout;

  // RAM is not reset: a write coincident with rst still lands.
  always_ff @(posedge clk) begin
    if (mem_wen && w_ram_hit) r_mem[w_idx] <= mem_dout;
  end

  mmio_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (w_tmr_wr),
    .o_load    (w_load),
    .o_count   (w_count),
    .o_ctrl    (w_ctrl),
    .o_pending (w_pending),
    .o_irq     (interrupter)
  );

  // Reads see pre-edge state, so a same-cycle write returns the old value.
  always_comb begin
    w_rdata = '0;
    if (mem_ren) begin
      if (w_ram_hit) begin
        w_rdata = r_mem[w_idx];
      end else if (w_tmr_hit) begin
        unique case (w_sel)
          TMR_LOAD:   w_rdata = w_load;
          TMR_COUNT:  w_rdata = w_count;
          TMR_CTRL:   w_rdata = {{(32-CTRL_W){1'b0}}, w_ctrl};
          TMR_STATUS: w_rdata = {31'd0, w_pending};
        endcase
      end
    end
  end

  assign mem_din = w_rdata;

endmodule
